alu_mul_seq: RTL and testbench

Multi-cycle sequencer that computes the unsigned 32x32 low-word product (RISC-V MUL semantics) using the shared ALU's adder. It runs shift-and-add iterations.
- Idle: the core datapath's ALU request passes straight through.
- Running: the sequencer owns the ALU and stalls the datapath.
Sits between the decode/execute datapath and the ALU instance.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_port_mux.sv | 29 ++
 rtl/alu_mul_seq.sv | 113 +++++++++++
 tb/tb_alu_mul_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, default widths and the multiply sequencer state type.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;
  localparam int ALU_CTRL_WIDTH = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_port_mux.sv
// Selects who drives the shared ALU: the core datapath or a multi-cycle sequencer.
module alu_port_mux #(
  parameter int DATA_WIDTH    = 32,
  parameter int ALUCTRL_WIDTH = 3
) (
  input  logic                     sel_seq,
  input  logic [ALUCTRL_WIDTH-1:0] dp_ctrl,
  input  logic [DATA_WIDTH-1:0]    dp_op1,
  input  logic [DATA_WIDTH-1:0]    dp_op2,
  input  logic [ALUCTRL_WIDTH-1:0] seq_ctrl,
  input  logic [DATA_WIDTH-1:0]    seq_op1,
  input  logic [DATA_WIDTH-1:0]    seq_op2,
  output logic [ALUCTRL_WIDTH-1:0] alu_ctrl,
  output logic [DATA_WIDTH-1:0]    alu_op1,
  output logic [DATA_WIDTH-1:0]    alu_op2
);

  always_comb begin
    alu_ctrl = dp_ctrl;
    alu_op1  = dp_op1;
    alu_op2  = dp_op2;
    if (sel_seq) begin
      alu_ctrl = seq_ctrl;
      alu_op1  = seq_op1;
      alu_op2  = seq_op2;
    end
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add 32x32 low-word multiplier that borrows the shared ALU adder.
// Optional macro EARLY_TERM_EN: stop as soon as the remaining multiplier bits are zero.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = ALU_DATA_WIDTH,
  parameter int ALUCTRL_WIDTH = ALU_CTRL_WIDTH,
  parameter int CNT_WIDTH     = $clog2(DATA_WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    mul_a,
  input  logic [DATA_WIDTH-1:0]    mul_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    product,
  input  logic [ALUCTRL_WIDTH-1:0] dp_ALUCtrl,
  input  logic [DATA_WIDTH-1:0]    dp_ALUOP1,
  input  logic [DATA_WIDTH-1:0]    dp_ALUOP2,
  output logic                     dp_stall,
  output logic [ALUCTRL_WIDTH-1:0] ALUCtrl,
  output logic [DATA_WIDTH-1:0]    ALUOP1,
  output logic [DATA_WIDTH-1:0]    ALUOP2,
  input  logic [DATA_WIDTH-1:0]    SUM
);

  mul_state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0] acc_reg;
  logic [DATA_WIDTH-1:0] mcand_reg;
  logic [DATA_WIDTH-1:0] mplier_reg;
  logic [DATA_WIDTH-1:0] product_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg;
  logic [DATA_WIDTH-1:0] seq_op2;
  logic                  last_iter;

  // Partial product: add the multiplicand only when the current multiplier bit is set.
  assign seq_op2 = mcand_reg & {DATA_WIDTH{mplier_reg[0]}};

`ifdef EARLY_TERM_EN
  assign last_iter = (cnt_reg == CNT_WIDTH'(DATA_WIDTH - 1)) || ((mplier_reg >> 1) == '0);
`else
  assign last_iter = (cnt_reg == CNT_WIDTH'(DATA_WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            acc_reg    <= '0;
            mcand_reg  <= mul_a;
            mplier_reg <= mul_b;
            cnt_reg    <= '0;
          end
        end
        RUN: begin
          acc_reg    <= SUM;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + CNT_WIDTH'(1);
          if (last_iter) product_reg <= SUM;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign dp_stall  = (state_reg == RUN);
  assign out_valid = (state_reg == DONE);
  assign product   = product_reg;

  alu_port_mux #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ALUCTRL_WIDTH(ALUCTRL_WIDTH)
  ) u_port_mux (
    .sel_seq (dp_stall),
    .dp_ctrl (dp_ALUCtrl),
    .dp_op1  (dp_ALUOP1),
    .dp_op2  (dp_ALUOP2),
    .seq_ctrl(ALUCTRL_WIDTH'(ALU_ADD)),
    .seq_op1 (acc_reg),
    .seq_op2 (seq_op2),
    .alu_ctrl(ALUCtrl),
    .alu_op1 (ALUOP1),
    .alu_op2 (ALUOP2)
  );

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural ALU and a 64-bit multiply reference.
module tb_alu_mul_seq;
  import alu_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] mul_a, mul_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] product;
  logic [2:0]    dp_ALUCtrl;
  logic [DW-1:0] dp_ALUOP1, dp_ALUOP2;
  logic          dp_stall;
  logic [2:0]    ALUCtrl;
  logic [DW-1:0] ALUOP1, ALUOP2;
  logic [DW-1:0] SUM;

  typedef struct {
    logic [DW-1:0] prod;
    int            t;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   force_mode = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mul_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mul_a(mul_a), .mul_b(mul_b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .dp_ALUCtrl(dp_ALUCtrl), .dp_ALUOP1(dp_ALUOP1), .dp_ALUOP2(dp_ALUOP2),
    .dp_stall(dp_stall),
    .ALUCtrl(ALUCtrl), .ALUOP1(ALUOP1), .ALUOP2(ALUOP2), .SUM(SUM)
  );

  // Behavioural shared ALU
  always_comb begin
    SUM = '0;
    case (ALUCtrl)
      ALU_ADD: SUM = ALUOP1 + ALUOP2;
      ALU_SUB: SUM = ALUOP1 - ALUOP2;
      ALU_AND: SUM = ALUOP1 & ALUOP2;
      ALU_OR:  SUM = ALUOP1 | ALUOP2;
      ALU_SLT: SUM = {31'b0, $signed(ALUOP1) < $signed(ALUOP2)};
      default: SUM = '0;
    endcase
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_runs(input logic [DW-1:0] b);
`ifdef EARLY_TERM_EN
    int n = 0;
    for (int i = 0; i < DW; i++) if (b[i]) n = i + 1;
    return (n < 1) ? 1 : n;
`else
    return DW;
`endif
  endfunction

  function automatic logic [DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [63:0] full;
    full = {32'b0, a} * {32'b0, b};
    return full[DW-1:0];
  endfunction

  task automatic push_exp(input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.prod = ref_mul(a, b);
    e.t    = cyc + 1;
    e.due  = cyc + 1 + exp_runs(b);
    sb.push_back(e);
    $display("issue a=%h b=%h expect=%h accept_edge=%0d valid_edge=%0d", a, b, e.prod, e.t, e.due);
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int g = 0;
    @(posedge clk); #2;
    in_valid = 1'b1; mul_a = a; mul_b = b;
    while (!in_ready && g < 500) begin
      @(posedge clk); #2;
      g++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'b0, in_ready}, 32'd1);
    end else begin
      push_exp(a, b);
    end
    @(posedge clk); #2;
    in_valid = 1'b0; mul_a = $urandom; mul_b = $urandom;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 400) begin
      @(posedge clk); #2;
      g++;
    end
    chk("drain_timeout", sb.size(), 32'd0);
  endtask

  // Random datapath traffic and consumer readiness
  initial begin
    forever begin
      @(posedge clk); #1;
      dp_ALUCtrl = 3'($urandom);
      dp_ALUOP1  = $urandom;
      dp_ALUOP2  = $urandom;
      if (!force_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: expectations derived purely from scoreboard timing
  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_busy, exp_valid;
      exp_busy  = (sb.size() > 0) && (cyc >= sb[0].t);
      exp_valid = exp_busy && (cyc >= sb[0].due);
      chk("in_ready", {31'b0, in_ready}, {31'b0, !exp_busy});
      chk("dp_stall", {31'b0, dp_stall}, {31'b0, exp_busy && !exp_valid});
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      if (exp_busy && !exp_valid) begin
        chk("seq_aluctrl", {29'b0, ALUCtrl}, {29'b0, ALU_ADD});
      end else begin
        chk("pass_ctrl", {29'b0, ALUCtrl}, {29'b0, dp_ALUCtrl});
        chk("pass_op1", ALUOP1, dp_ALUOP1);
        chk("pass_op2", ALUOP2, dp_ALUOP2);
      end
      if (exp_valid && out_valid) begin
        chk("product", product, sb[0].prod);
        if (out_ready) begin
          $display("complete product=%h expect=%h cycle=%0d", product, sb[0].prod, cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int g;
    logic [DW-1:0] a, b;
    rst_n = 1'b0; in_valid = 1'b1; mul_a = 32'd9; mul_b = 32'd9; out_ready = 1'b1;
    dp_ALUCtrl = '0; dp_ALUOP1 = '0; dp_ALUOP2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_dp_stall", {31'b0, dp_stall}, 32'd0);
    chk("rst_pass_op1", ALUOP1, dp_ALUOP1);
    @(posedge clk); #2;
    rst_n = 1'b1; in_valid = 1'b0;

    // Directed corner products
    send(32'd7, 32'd6);
    drain();
    send(32'hFFFF_FFFF, 32'd2);
    drain();
    send(32'h8000_0000, 32'h8000_0000);
    drain();
    send(32'h1357_9BDF, 32'd0);
    drain();
    send(32'h0001_2345, 32'd5);
    drain();

    // Backpressure: hold DONE for 5 cycles while a new request waits
    force_mode = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    send(32'h0000_1234, 32'd3);
    g = 0;
    while (!out_valid && g < 100) begin
      @(posedge clk); #2;
      g++;
    end
    chk("bp_reach_done", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b1; mul_a = 32'd11; mul_b = 32'd13;
    repeat (5) begin
      @(posedge clk); #2;
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_no_accept", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_idle_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_idle_valid", {31'b0, out_valid}, 32'd0);
    force_mode = 1'b0;
    push_exp(32'd11, 32'd13);
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("bp_accepted", {31'b0, in_ready}, 32'd0);
    drain();

    // Reset in the middle of a run discards the result
    send(32'h0000_DEAD, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    sb.delete();
    chk("midrst_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    repeat (40) @(posedge clk);
    send(32'd3, 32'd5);
    drain();

    // Randomized traffic, mixing wide and narrow multipliers
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom_range(0, 1) ? $urandom : (($urandom & 32'hFF) >> $urandom_range(0, 8));
      send(a, b);
    end
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
